// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the main-control decode stage.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_I_TYPE64 = 7'b0011011;
  localparam logic [6:0] OP_R_TYPE64 = 7'b0111011;

  // Control word handed to the execute stage; illegal=1 means all other fields are zero.
  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
    logic       src_a_src;
    logic       jump_reg;
    logic       is_word_op;
    logic       illegal;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction -> control word decode with illegal-encoding detection.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0] instr,
  output ctrl_word_t  ctrl
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;
  logic       bad;
  ctrl_word_t dec;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31:15], instr[11:7]};

  // Decode fields per opcode, then squash everything but illegal for bad encodings.
  always_comb begin
    dec = '0;
    bad = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.jump_reg   = 1'b1;
        dec.is_word_op = (funct3 == 3'b110);
        bad = (funct3 == 3'b111) || (!IS64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.jump_reg  = 1'b1;
        bad = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (IS64 && funct3 == 3'b011));
      end
      OP_R_TYPE: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.jump_reg  = 1'b1;
      end
      OP_I_TYPE: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
        dec.jump_reg  = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_op   = 2'b01;
        dec.jump_reg = 1'b1;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b11;
        dec.jump_reg   = 1'b1;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.src_a_src = 1'b1;
        dec.jump_reg  = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.src_a_src  = 1'b1;
        dec.jump_reg   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        bad = (funct3 != 3'b000);
      end
      OP_I_TYPE64, OP_R_TYPE64: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = (opcode == OP_I_TYPE64);
        dec.alu_op     = 2'b10;
        dec.jump_reg   = 1'b1;
        dec.is_word_op = 1'b1;
        bad = !IS64 ||
              !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101));
      end
      default: bad = 1'b1;
    endcase

    ctrl = dec;
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_decode_skid.sv
// Decode stage with a 2-entry skid buffer on the output and a saturating illegal counter.
module ctrl_decode_skid
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output ctrl_word_t           out_ctrl,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  ctrl_word_t in_ctrl;

  buf_state_t           state_q, state_d;
  ctrl_word_t           head_ctrl_q, head_ctrl_d;
  logic [31:0]          head_instr_q, head_instr_d;
  logic [XLEN-1:0]      head_pc_q, head_pc_d;
  ctrl_word_t           skid_ctrl_q, skid_ctrl_d;
  logic [31:0]          skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]      skid_pc_q, skid_pc_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic acc;
  logic pop;

  ctrl_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .ctrl  (in_ctrl)
  );

  assign in_ready      = (state_q != FULL) && !reset;
  assign out_valid     = (state_q != EMPTY);
  assign acc           = in_valid && in_ready;
  assign pop           = out_valid && out_ready;
  assign out_ctrl      = head_ctrl_q;
  assign out_instr     = head_instr_q;
  assign out_pc        = head_pc_q;
  assign illegal_count = ill_cnt_q;

  // Next-state for buffer occupancy, head/skid entries and the illegal counter.
  always_comb begin
    state_d      = state_q;
    head_ctrl_d  = head_ctrl_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ill_cnt_d    = ill_cnt_q;

    case (state_q)
      EMPTY: begin
        if (acc) begin
          head_ctrl_d  = in_ctrl;
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          head_ctrl_d  = in_ctrl;
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
        end else if (acc) begin
          skid_ctrl_d  = in_ctrl;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
          state_d      = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_ctrl_d  = skid_ctrl_q;
          head_instr_d = skid_instr_q;
          head_pc_d    = skid_pc_q;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (pop && head_ctrl_q.illegal && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end

    // A same-cycle pop still counts above; flush only discards occupancy.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Register all state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      head_ctrl_q  <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_ctrl_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ill_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_ctrl_q  <= head_ctrl_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

endmodule
